ctrl_bank_sched: RTL and testbench
==================================

Name: ctrl_bank_sched

Overview:
- Parametrised per-bank scheduler; successor to the single-bank ctrl_burst_act/ctrl_burst_cas path.
- Buffers host requests and tracks the open row and timing counters of every bank.
- Issues ACT/PRE/RD/WR/PREA with an open-page policy, plus refresh arbitration.
- Sits between the controller FSM request side and the command encoder (ctrl_cmds).

Parameters:
- NUM_BANKS, 16, total banks (bank groups × banks per group); power of 2
- ROW_W, 17, row address width
- COL_W, 10, column address width
- QDEPTH, 4, request FIFO depth; power of 2, ≥2
- T_RCD, 16, ACT→CAS same bank, cycles
- T_RP, 16, PRE→ACT same bank, cycles
- T_RAS, 39, ACT→PRE same bank, cycles
- T_CCD, 4, CAS→CAS any bank, cycles

Ports:
- clock  in  1  controller clock
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  request present
- req_ready  out  1  FIFO not full
- req_rw  in  1  1=write, 0=read
- req_bank  in  $clog2(NUM_BANKS)  flat bank index
- req_row  in  ROW_W  row
- req_col  in  COL_W  column
- ref_req  in  1  refresh needed (level)
- ref_ack  out  1  one-cycle pulse: all banks precharged, tRP met
- cmd_valid  out  1  one-cycle command pulse
- cmd_op  out  3  0 NOP,1 ACT,2 PRE,3 RD,4 WR,5 PREA
- cmd_bank  out  $clog2(NUM_BANKS)  target bank
- cmd_row  out  ROW_W  ACT row, else 0
- cmd_col  out  COL_W  RD/WR column, else 0
- busy  out  1  FIFO non-empty or FSM not IDLE

Behaviour:
- Reset (asynchronous, active-low): FIFO emptied, all banks closed, all counters saturated (constraints satisfied), FSM→IDLE. Outputs: req_ready=1, cmd_valid=0, cmd_op=NOP, cmd_bank/row/col=0, ref_ack=0, busy=0.
- FIFO: push when req_valid&&req_ready. Pop occurs on the CAS cycle of the head entry. req_ready=!full, registered-free. Push and pop in the same cycle are both allowed when not full; at full the push is blocked. Pointers wrap modulo QDEPTH.
- Per-bank state: open flag, open_row, act_cnt (cycles since ACT), pre_cnt (cycles since PRE). Counters saturate at max(T_RAS,T_RP,T_RCD).
- Global ccd_cnt (cycles since last CAS), saturating.
- At most one command per cycle. cmd_* is registered; the command appears the cycle after the FSM decision.
- FSM states: IDLE, DECIDE, PRE, ACT, CAS, REF_PREA, REF_WAIT.
  - IDLE→DECIDE when the FIFO is non-empty or ref_req=1.
  - DECIDE: ref_req=1 takes priority → REF_PREA. Otherwise the head entry decides the next state:
    - bank open with matching row → CAS (hit)
    - bank open with different row → PRE (miss)
    - bank closed → ACT
  - PRE: wait act_cnt≥T_RAS; issue PRE; bank closes; pre_cnt=0; →ACT.
  - ACT: wait pre_cnt≥T_RP; issue ACT with req_row; act_cnt=0; open_row updated; →CAS.
  - CAS: wait act_cnt≥T_RCD and ccd_cnt≥T_CCD; issue RD/WR; ccd_cnt=0; pop. Then →DECIDE if the FIFO is still non-empty or ref_req=1, else →IDLE.
  - REF_PREA: if no bank is open → REF_WAIT immediately. Otherwise wait until every open bank has act_cnt≥T_RAS, issue PREA, close all banks, zero their pre_cnt, →REF_WAIT.
  - REF_WAIT: wait until all pre_cnt≥T_RP; pulse ref_ack; →IDLE.
- ref_req asserted mid-request does not interrupt PRE/ACT/CAS; it is serviced at the next DECIDE.
- ref_req deasserting during REF_* does not abort; ref_ack still pulses.
- Counters "wait ≥N" use cycles counted from the command's issue cycle. A constraint already satisfied issues on the next cycle.
- Reset asserted mid-operation aborts immediately and applies the reset values. No PRE is issued for open banks (the DRAM is reinitialised by ctrl_init).

Decomposition:
- Shared package ctrl_sched_pkg: cmd_op_e enum (NOP/ACT/PRE/RD/WR/PREA), sched_state_e enum, bank_state_t struct {open, open_row, act_cnt, pre_cnt}.
- One sub-module: ctrl_req_fifo (parametrised QDEPTH, data width 1+bank+ROW_W+COL_W, full/empty flags).

Test Plan (T_RCD=4, T_RP=4, T_RAS=10, T_CCD=2, NUM_BANKS=4):
- Reset check: after reset_n release → req_ready=1, cmd_op=NOP, busy=0. A push of RD bank1 row5 col8 → ACT b1 r5, then RD b1 c8 exactly 4 cycles after the ACT.
- Page hit: two reads bank0 row3 cols 0 and 8 → one ACT, CAS at +4, second CAS at +6 (T_CCD). No PRE.
- Page miss: WR b2 r1 then WR b2 r7 → PRE no earlier than 10 cycles after the first ACT, ACT r7 4 cycles after the PRE, WR 4 cycles after that.
- Backpressure: push 5 requests back-to-back with the FSM stalled on tRCD → req_ready=0 after 4 accepted; the 5th is accepted the cycle after the first pop.
- Refresh: banks 0 and 3 open, ref_req=1 → PREA once T_RAS is met, ref_ack 4 cycles later. The next request to bank 0 issues ACT (no hit).
- Reset mid-op: reset_n low during the ACT→CAS wait → cmd_valid=0 next edge, FIFO empty, all banks closed after release.

Source files
------------

// File: rtl/ctrl_sched_pkg.sv
// Shared types and helpers for the per-bank DRAM command scheduler.
package ctrl_sched_pkg;
  localparam int ROW_W_MAX = 24;  // widest row address an instance may use
  localparam int CNT_W     = 8;   // timing counters; every tXX must stay below 2**CNT_W

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_ACT  = 3'd1,
    OP_PRE  = 3'd2,
    OP_RD   = 3'd3,
    OP_WR   = 3'd4,
    OP_PREA = 3'd5
  } cmd_op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DECIDE,
    ST_PRE,
    ST_ACT,
    ST_CAS,
    ST_REF_PREA,
    ST_REF_WAIT
  } sched_state_e;

  typedef struct packed {
    logic                 open;
    logic [ROW_W_MAX-1:0] open_row;
    logic [CNT_W-1:0]     act_cnt;
    logic [CNT_W-1:0]     pre_cnt;
  } bank_state_t;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The decision cycle precedes the issue cycle, so t-1 here lands the new
  // command exactly t cycles after the command that cleared the counter.
  function automatic logic cnt_met(input logic [CNT_W-1:0] cnt, input int t);
    return (int'(cnt) + 1) >= t;
  endfunction
endpackage

// File: rtl/ctrl_req_fifo.sv
// Request FIFO: head is readable combinationally, pop retires it.
module ctrl_req_fifo #(
  parameter int QDEPTH = 4,
  parameter int DW     = 8
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      i_push,
  input  logic [DW-1:0]             i_data,
  input  logic                      i_pop,
  output logic [DW-1:0]             o_data,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(QDEPTH):0]   o_count
);
  localparam int PW = $clog2(QDEPTH);

  logic [DW-1:0] r_mem [QDEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [PW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_full  = (r_count == (PW+1)'(QDEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // NOTE: the storage array has no reset; only pointers and count need a known
  // value, and entries are never read before being written.
  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (PW+1)'(1);
        2'b01:   r_count <= r_count - (PW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ctrl_bank_sched.sv
// Open-page per-bank scheduler: buffers requests, tracks bank rows/timers,
// issues ACT/PRE/RD/WR/PREA one per cycle and arbitrates refresh.
module ctrl_bank_sched
  import ctrl_sched_pkg::*;
#(
  parameter int NUM_BANKS = 16,
  parameter int ROW_W     = 17,  // must not exceed ROW_W_MAX
  parameter int COL_W     = 10,
  parameter int QDEPTH    = 4,
  parameter int T_RCD     = 16,
  parameter int T_RP      = 16,
  parameter int T_RAS     = 39,
  parameter int T_CCD     = 4
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_rw,
  input  logic [$clog2(NUM_BANKS)-1:0] req_bank,
  input  logic [ROW_W-1:0]             req_row,
  input  logic [COL_W-1:0]             req_col,
  input  logic                         ref_req,
  output logic                         ref_ack,
  output logic                         cmd_valid,
  output logic [2:0]                   cmd_op,
  output logic [$clog2(NUM_BANKS)-1:0] cmd_bank,
  output logic [ROW_W-1:0]             cmd_row,
  output logic [COL_W-1:0]             cmd_col,
  output logic                         busy
);
  localparam int BW      = $clog2(NUM_BANKS);
  localparam int DW      = 1 + BW + ROW_W + COL_W;
  localparam int QCW     = $clog2(QDEPTH) + 1;
  localparam int CNT_MAX = max2(max2(T_RAS, T_RP), max2(T_RCD, T_CCD));
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(CNT_MAX);
  localparam bank_state_t BANK_RST = '{open: 1'b0, open_row: '0,
                                       act_cnt: CNT_SAT, pre_cnt: CNT_SAT};

  sched_state_e     r_state;
  sched_state_e     w_state_nxt;
  cmd_op_e          w_issue_op;
  logic             w_pop;
  logic             w_push;
  logic             w_ref_ack;
  logic             w_full;
  logic             w_empty;
  logic [QCW-1:0]   w_count;
  logic [DW-1:0]    w_head_data;
  logic             w_head_rw;
  logic [BW-1:0]    w_head_bank;
  logic [ROW_W-1:0] w_head_row;
  logic [COL_W-1:0] w_head_col;
  bank_state_t      w_head_bs;
  logic             w_any_open;
  logic             w_all_ras;
  logic             w_all_rp;

  bank_state_t      r_bank [NUM_BANKS];
  logic [CNT_W-1:0] r_ccd_cnt;
  logic             r_cmd_valid;
  cmd_op_e          r_cmd_op;
  logic [BW-1:0]    r_cmd_bank;
  logic [ROW_W-1:0] r_cmd_row;
  logic [COL_W-1:0] r_cmd_col;
  logic             r_ref_ack;

  assign w_push = req_valid && req_ready;

  ctrl_req_fifo #(.QDEPTH(QDEPTH), .DW(DW)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .i_push  (w_push),
    .i_data  ({req_rw, req_bank, req_row, req_col}),
    .i_pop   (w_pop),
    .o_data  (w_head_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign {w_head_rw, w_head_bank, w_head_row, w_head_col} = w_head_data;
  assign w_head_bs = r_bank[w_head_bank];

  // Refresh gating: every open bank must have served tRAS; every bank tRP.
  always_comb begin
    w_any_open = 1'b0;
    w_all_ras  = 1'b1;
    w_all_rp   = 1'b1;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (r_bank[b].open) begin
        w_any_open = 1'b1;
        if (!cnt_met(r_bank[b].act_cnt, T_RAS)) w_all_ras = 1'b0;
      end
      if (!cnt_met(r_bank[b].pre_cnt, T_RP)) w_all_rp = 1'b0;
    end
  end

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement can leave a value held and infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_issue_op  = OP_NOP;
    w_pop       = 1'b0;
    w_ref_ack   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty || ref_req) w_state_nxt = ST_DECIDE;
      end
      ST_DECIDE: begin
        if (ref_req)                 w_state_nxt = ST_REF_PREA;
        else if (w_empty)            w_state_nxt = ST_IDLE;
        else if (!w_head_bs.open)    w_state_nxt = ST_ACT;
        else if (w_head_bs.open_row == ROW_W_MAX'(w_head_row))
                                     w_state_nxt = ST_CAS;
        else                         w_state_nxt = ST_PRE;
      end
      ST_PRE: begin
        if (cnt_met(w_head_bs.act_cnt, T_RAS)) begin
          w_issue_op  = OP_PRE;
          w_state_nxt = ST_ACT;
        end
      end
      ST_ACT: begin
        if (cnt_met(w_head_bs.pre_cnt, T_RP)) begin
          w_issue_op  = OP_ACT;
          w_state_nxt = ST_CAS;
        end
      end
      ST_CAS: begin
        if (cnt_met(w_head_bs.act_cnt, T_RCD) && cnt_met(r_ccd_cnt, T_CCD)) begin
          w_issue_op  = w_head_rw ? OP_WR : OP_RD;
          w_pop       = 1'b1;
          // The head leaves this cycle; more work exists only beyond it.
          w_state_nxt = (w_count > QCW'(1) || w_push || ref_req) ? ST_DECIDE : ST_IDLE;
        end
      end
      ST_REF_PREA: begin
        if (!w_any_open) begin
          w_state_nxt = ST_REF_WAIT;
        end else if (w_all_ras) begin
          w_issue_op  = OP_PREA;
          w_state_nxt = ST_REF_WAIT;
        end
      end
      ST_REF_WAIT: begin
        if (w_all_rp) begin
          w_ref_ack   = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int b = 0; b < NUM_BANKS; b++) r_bank[b] <= BANK_RST;
      r_ccd_cnt <= CNT_SAT;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (r_bank[b].act_cnt < CNT_SAT) r_bank[b].act_cnt <= r_bank[b].act_cnt + CNT_W'(1);
        if (r_bank[b].pre_cnt < CNT_SAT) r_bank[b].pre_cnt <= r_bank[b].pre_cnt + CNT_W'(1);
        if (w_issue_op == OP_PREA && r_bank[b].open) begin
          r_bank[b].open    <= 1'b0;
          r_bank[b].pre_cnt <= '0;
        end
        if (BW'(b) == w_head_bank) begin
          if (w_issue_op == OP_ACT) begin
            r_bank[b].open     <= 1'b1;
            r_bank[b].open_row <= ROW_W_MAX'(w_head_row);
            r_bank[b].act_cnt  <= '0;
          end else if (w_issue_op == OP_PRE) begin
            r_bank[b].open    <= 1'b0;
            r_bank[b].pre_cnt <= '0;
          end
        end
      end
      if (w_issue_op == OP_RD || w_issue_op == OP_WR) r_ccd_cnt <= '0;
      else if (r_ccd_cnt < CNT_SAT)                   r_ccd_cnt <= r_ccd_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_cmd_valid <= 1'b0;
      r_cmd_op    <= OP_NOP;
      r_cmd_bank  <= '0;
      r_cmd_row   <= '0;
      r_cmd_col   <= '0;
      r_ref_ack   <= 1'b0;
    end else begin
      r_cmd_valid <= (w_issue_op != OP_NOP);
      r_cmd_op    <= w_issue_op;
      r_cmd_bank  <= (w_issue_op == OP_NOP || w_issue_op == OP_PREA) ? '0 : w_head_bank;
      r_cmd_row   <= (w_issue_op == OP_ACT) ? w_head_row : '0;
      r_cmd_col   <= (w_issue_op == OP_RD || w_issue_op == OP_WR) ? w_head_col : '0;
      r_ref_ack   <= w_ref_ack;
    end
  end

  assign req_ready = !w_full;
  assign cmd_valid = r_cmd_valid;
  assign cmd_op    = r_cmd_op;
  assign cmd_bank  = r_cmd_bank;
  assign cmd_row   = r_cmd_row;
  assign cmd_col   = r_cmd_col;
  assign ref_ack   = r_ref_ack;
  assign busy      = !w_empty || (r_state != ST_IDLE);
endmodule

// File: tb/tb_ctrl_bank_sched.sv
// Directed bench for ctrl_bank_sched with small timing parameters.
module tb_ctrl_bank_sched;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [1:0]  req_bank = '0;
  logic [16:0] req_row = '0;
  logic [9:0]  req_col = '0;
  logic        ref_req = 1'b0;
  logic        ref_ack;
  logic        cmd_valid;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_bank;
  logic [16:0] cmd_row;
  logic [9:0]  cmd_col;
  logic        busy;

  always #5 clock = ~clock;

  ctrl_bank_sched #(
    .NUM_BANKS(4), .ROW_W(17), .COL_W(10), .QDEPTH(4),
    .T_RCD(4), .T_RP(4), .T_RAS(10), .T_CCD(2)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_bank(req_bank), .req_row(req_row), .req_col(req_col),
    .ref_req(ref_req), .ref_ack(ref_ack),
    .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_bank(cmd_bank),
    .cmd_row(cmd_row), .cmd_col(cmd_col), .busy(busy)
  );

  typedef struct { int op; int bank; int row; int col; int cyc; } cmd_rec_t;

  cmd_rec_t cmd_q[$];
  int       ack_q[$];
  int       cyc = 0;
  int       n_pass = 0;
  int       n_total = 0;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (reset_n && cmd_valid)
      cmd_q.push_back('{int'(cmd_op), int'(cmd_bank), int'(cmd_row), int'(cmd_col), cyc});
    if (reset_n && ref_ack) ack_q.push_back(cyc);
  end

  function automatic string fmt(input cmd_rec_t c);
    return $sformatf("op=%0d bank=%0d row=%0d col=%0d @%0d", c.op, c.bank, c.row, c.col, c.cyc);
  endfunction

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic get_cmd(input string name, output cmd_rec_t c);
    int n = 0;
    while (cmd_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    if (cmd_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: no command within 200 cycles, required one", name);
      c = '{-1, -1, -1, -1, -1000};
    end else begin
      c = cmd_q.pop_front();
    end
  endtask

  task automatic get_ack(input string name, output int at);
    int n = 0;
    while (ack_q.size() == 0 && n < 200) begin
      tick();
      n++;
    end
    if (ack_q.size() == 0) begin
      n_total++;
      $display("FAIL %s: no ref_ack within 200 cycles, required a pulse", name);
      at = -1000;
    end else begin
      at = ack_q.pop_front();
    end
  endtask

  // Leaves req_valid high so consecutive calls push back-to-back.
  task automatic push(input bit rw, input int bank, input int row, input int col, output int acc);
    int n = 0;
    req_valid = 1'b1;
    req_rw    = rw;
    req_bank  = 2'(bank);
    req_row   = 17'(row);
    req_col   = 10'(col);
    while (!req_ready && n < 100) begin
      tick();
      n++;
    end
    acc = cyc + 1;
    if (!req_ready) begin
      n_total++;
      $display("FAIL push: req_ready=0 for 100 cycles, required 1");
      acc = -1000;
    end
    tick();
  endtask

  task automatic do_reset();
    req_valid = 1'b0;
    ref_req   = 1'b0;
    reset_n   = 1'b0;
    repeat (2) tick();
    reset_n = 1'b1;
    tick();
    cmd_q.delete();
    ack_q.delete();
  endtask

  task automatic test_reset();
    cmd_rec_t a, r;
    int acc;
    reset_n = 1'b0;
    repeat (3) tick();
    n_total++;
    if ({cmd_valid, req_ready, busy, ref_ack} !== 4'b0100)
      $display("FAIL rst_hold: valid/ready/busy/ack=%b, required 0100", {cmd_valid, req_ready, busy, ref_ack});
    else n_pass++;
    reset_n = 1'b1;
    tick();
    n_total++;
    if ({req_ready, busy, cmd_op, cmd_bank, cmd_row, cmd_col} !== {1'b1, 1'b0, 3'd0, 2'd0, 17'd0, 10'd0})
      $display("FAIL rst_out: ready=%b busy=%b op=%0d bank=%0d row=%0d col=%0d, required 1 0 0 0 0 0",
               req_ready, busy, cmd_op, cmd_bank, cmd_row, cmd_col);
    else n_pass++;
    push(1'b0, 1, 5, 8, acc);
    req_valid = 1'b0;
    get_cmd("rst_act", a);
    n_total++;
    if (a.op !== 1 || a.bank !== 1 || a.row !== 5 || a.col !== 0)
      $display("FAIL rst_act: got %s, required op=1 bank=1 row=5 col=0", fmt(a));
    else n_pass++;
    get_cmd("rst_rd", r);
    n_total++;
    if (r.op !== 3 || r.bank !== 1 || r.row !== 0 || r.col !== 8 || r.cyc - a.cyc !== 4)
      $display("FAIL rst_rd: got %s (ACT @%0d), required op=3 bank=1 row=0 col=8 at ACT+4", fmt(r), a.cyc);
    else n_pass++;
  endtask

  task automatic test_page_hit();
    cmd_rec_t a, r0, r1;
    int acc;
    push(1'b0, 0, 3, 0, acc);
    push(1'b0, 0, 3, 8, acc);
    req_valid = 1'b0;
    get_cmd("hit_act", a);
    n_total++;
    if (a.op !== 1 || a.bank !== 0 || a.row !== 3)
      $display("FAIL hit_act: got %s, required op=1 bank=0 row=3", fmt(a));
    else n_pass++;
    get_cmd("hit_rd0", r0);
    n_total++;
    if (r0.op !== 3 || r0.col !== 0 || r0.cyc - a.cyc !== 4)
      $display("FAIL hit_rd0: got %s, required op=3 col=0 at ACT+4 (@%0d)", fmt(r0), a.cyc + 4);
    else n_pass++;
    get_cmd("hit_rd1", r1);
    n_total++;
    if (r1.op !== 3 || r1.col !== 8 || r1.cyc - a.cyc !== 6)
      $display("FAIL hit_rd1: got %s, required op=3 col=8 at ACT+6 (@%0d)", fmt(r1), a.cyc + 6);
    else n_pass++;
    repeat (20) tick();
    n_total++;
    if (cmd_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL hit_quiet: extra cmds=%0d busy=%b, required 0 and 0", cmd_q.size(), busy);
    else n_pass++;
  endtask

  task automatic test_page_miss();
    cmd_rec_t a0, w0, p, a1, w1;
    int acc;
    push(1'b1, 2, 1, 2, acc);
    push(1'b1, 2, 7, 3, acc);
    req_valid = 1'b0;
    get_cmd("miss_act0", a0);
    get_cmd("miss_wr0", w0);
    n_total++;
    if (a0.op !== 1 || a0.bank !== 2 || a0.row !== 1 || w0.op !== 4 || w0.col !== 2 || w0.cyc - a0.cyc !== 4)
      $display("FAIL miss_first: got %s / %s, required ACT b2 r1 then WR c2 at +4", fmt(a0), fmt(w0));
    else n_pass++;
    get_cmd("miss_pre", p);
    n_total++;
    if (p.op !== 2 || p.bank !== 2 || p.row !== 0 || p.col !== 0 || p.cyc - a0.cyc !== 10)
      $display("FAIL miss_pre: got %s, required op=2 bank=2 at ACT+10 (@%0d)", fmt(p), a0.cyc + 10);
    else n_pass++;
    get_cmd("miss_act1", a1);
    n_total++;
    if (a1.op !== 1 || a1.bank !== 2 || a1.row !== 7 || a1.cyc - p.cyc !== 4)
      $display("FAIL miss_act1: got %s, required op=1 bank=2 row=7 at PRE+4 (@%0d)", fmt(a1), p.cyc + 4);
    else n_pass++;
    get_cmd("miss_wr1", w1);
    n_total++;
    if (w1.op !== 4 || w1.bank !== 2 || w1.col !== 3 || w1.cyc - a1.cyc !== 4)
      $display("FAIL miss_wr1: got %s, required op=4 bank=2 col=3 at ACT+4 (@%0d)", fmt(w1), a1.cyc + 4);
    else n_pass++;
  endtask

  task automatic test_backpressure();
    cmd_rec_t a, r, prev;
    int acc [5];
    for (int i = 0; i < 4; i++) push(1'b0, 3, 2, i, acc[i]);
    n_total++;
    if (req_ready !== 1'b0 || acc[3] - acc[0] !== 3)
      $display("FAIL bp_full: ready=%b span=%0d, required ready=0 span=3", req_ready, acc[3] - acc[0]);
    else n_pass++;
    push(1'b0, 3, 2, 4, acc[4]);
    req_valid = 1'b0;
    get_cmd("bp_act", a);
    n_total++;
    if (a.op !== 1 || a.bank !== 3 || a.row !== 2)
      $display("FAIL bp_act: got %s, required op=1 bank=3 row=2", fmt(a));
    else n_pass++;
    get_cmd("bp_rd0", prev);
    n_total++;
    if (prev.op !== 3 || prev.col !== 0 || prev.cyc - a.cyc !== 4)
      $display("FAIL bp_rd0: got %s, required op=3 col=0 at ACT+4", fmt(prev));
    else n_pass++;
    n_total++;
    if (acc[4] !== prev.cyc + 1)
      $display("FAIL bp_fifth: accepted @%0d, required @%0d (pop+1)", acc[4], prev.cyc + 1);
    else n_pass++;
    for (int i = 1; i < 5; i++) begin
      get_cmd("bp_rd", r);
      n_total++;
      if (r.op !== 3 || r.bank !== 3 || r.col !== i || r.cyc - prev.cyc !== 2)
        $display("FAIL bp_rd%0d: got %s, required op=3 bank=3 col=%0d at prev+2", i, fmt(r), i);
      else n_pass++;
      prev = r;
    end
  endtask

  task automatic test_refresh();
    cmd_rec_t a0, r0, a3, r3, pa, nx;
    int t_set, at, acc;
    do_reset();
    t_set = cyc;
    ref_req = 1'b1;
    get_ack("ref_idle", at);
    ref_req = 1'b0;
    n_total++;
    if (at - t_set !== 4 || cmd_q.size() !== 0)
      $display("FAIL ref_idle: ack @+%0d cmds=%0d, required @+4 with no command", at - t_set, cmd_q.size());
    else n_pass++;
    push(1'b0, 0, 4, 0, acc);
    push(1'b0, 3, 6, 0, acc);
    req_valid = 1'b0;
    get_cmd("ref_act0", a0);
    get_cmd("ref_rd0", r0);
    get_cmd("ref_act3", a3);
    get_cmd("ref_rd3", r3);
    n_total++;
    if (a0.op !== 1 || a0.bank !== 0 || r0.op !== 3 || a3.op !== 1 || a3.bank !== 3 || r3.op !== 3 || r3.bank !== 3)
      $display("FAIL ref_open: got %s | %s | %s | %s, required ACT0 RD0 ACT3 RD3",
               fmt(a0), fmt(r0), fmt(a3), fmt(r3));
    else n_pass++;
    ref_req = 1'b1;
    get_cmd("ref_prea", pa);
    n_total++;
    if (pa.op !== 5 || pa.bank !== 0 || pa.row !== 0 || pa.col !== 0 || pa.cyc - a3.cyc !== 10)
      $display("FAIL ref_prea: got %s, required op=5 bank=0 at ACT3+10 (@%0d)", fmt(pa), a3.cyc + 10);
    else n_pass++;
    get_ack("ref_ack", at);
    ref_req = 1'b0;
    n_total++;
    if (at - pa.cyc !== 4)
      $display("FAIL ref_ack: ack @%0d, required @%0d (PREA+4)", at, pa.cyc + 4);
    else n_pass++;
    push(1'b0, 0, 4, 1, acc);
    req_valid = 1'b0;
    get_cmd("ref_reopen", nx);
    n_total++;
    if (nx.op !== 1 || nx.bank !== 0 || nx.row !== 4)
      $display("FAIL ref_reopen: got %s, required op=1 bank=0 row=4 (no hit)", fmt(nx));
    else n_pass++;
    get_cmd("ref_rd", nx);
    repeat (5) tick();
  endtask

  task automatic test_reset_midop();
    cmd_rec_t a, r;
    int acc;
    push(1'b0, 1, 9, 0, acc);
    req_valid = 1'b0;
    get_cmd("mid_act", a);
    n_total++;
    if (a.op !== 1 || a.bank !== 1 || a.row !== 9)
      $display("FAIL mid_act: got %s, required op=1 bank=1 row=9", fmt(a));
    else n_pass++;
    while (cyc < a.cyc + 3) tick();
    reset_n = 1'b0;
    tick();
    n_total++;
    if ({cmd_valid, cmd_op, req_ready, busy} !== {1'b0, 3'd0, 1'b1, 1'b0})
      $display("FAIL mid_rst: valid=%b op=%0d ready=%b busy=%b, required 0 0 1 0",
               cmd_valid, cmd_op, req_ready, busy);
    else n_pass++;
    reset_n = 1'b1;
    repeat (8) tick();
    n_total++;
    if (cmd_q.size() !== 0 || busy !== 1'b0)
      $display("FAIL mid_quiet: cmds=%0d busy=%b after release, required 0 and 0", cmd_q.size(), busy);
    else n_pass++;
    push(1'b0, 1, 9, 0, acc);
    req_valid = 1'b0;
    get_cmd("mid_reopen", a);
    get_cmd("mid_rd", r);
    n_total++;
    if (a.op !== 1 || a.bank !== 1 || a.row !== 9 || r.op !== 3 || r.cyc - a.cyc !== 4)
      $display("FAIL mid_reopen: got %s / %s, required ACT b1 r9 then RD at +4", fmt(a), fmt(r));
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_page_hit();
    test_page_miss();
    test_backpressure();
    test_refresh();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: run exceeded 300000 time units, required completion");
    $fatal(1, "watchdog");
  end
endmodule
